// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   UART receive engine for 8N1 framing. Oversamples the serial line at 16x the
//   baud rate, recovers start / DATA_WIDTH data bits (LSB first) / stop, and
//   hands each good byte to the RX FIFO with a single-clk write strobe.
//   Framing errors and overruns are reported as single-clk pulses.
//
// Parameters
//   DATA_WIDTH  payload bits per frame
//   BAUD_DIV    clk cycles per 16x-oversample tick (>= 2)
//   OVERSAMPLE  ticks per bit period (fixed at 16)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   rxd           serial input, idle high, asynchronous to clk
//   rx_fifo_full  RX FIFO full, sampled when the write would occur
//   rx_data       last received byte; valid with wr_en_rx, held afterwards
//   wr_en_rx      1-clk write strobe to the RX FIFO
//   frame_err     1-clk pulse: stop bit sampled low
//   overrun_err   1-clk pulse: good frame dropped because the FIFO was full
//   busy          high from start-bit detect until return to idle
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 326,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic                  rx_fifo_full,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  wr_en_rx,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BC_W  = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       SC_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]       SC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Two-flop synchronizer for the asynchronous serial line.
  logic rxd_meta_q;
  logic rxd_s_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Free-running oversample tick generator.
  logic [CNT_W-1:0] cnt_q;
  logic             tick;

  assign tick = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Receive FSM with registered outputs.
  state_e                state_q;
  logic                  prev_q;
  logic [3:0]            sc_q;
  logic [BC_W-1:0]       bc_q;
  logic [DATA_WIDTH-1:0] sh_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prev_q      <= 1'b1;
      sc_q        <= '0;
      bc_q        <= '0;
      sh_q        <= '0;
      rx_data     <= '0;
      wr_en_rx    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // NOTE: strobes default low every clk so each one lasts exactly one clk;
      // only the tick that samples the stop bit can raise them.
      wr_en_rx    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;

      if (tick) begin
        // Tracking the line on every tick means a stop bit sampled low leaves
        // prev_q low, so a stuck-low line cannot retrigger until it goes high.
        prev_q <= rxd_s_q;

        case (state_q)
          ST_IDLE: begin
            if (prev_q && !rxd_s_q) begin
              state_q <= ST_START;
              sc_q    <= '0;
              busy    <= 1'b1;
            end
          end

          ST_START: begin
            if (sc_q == SC_MID) begin
              if (rxd_s_q) begin
                // Line back high mid start bit: treat as a glitch.
                state_q <= ST_IDLE;
                busy    <= 1'b0;
              end else begin
                state_q <= ST_DATA;
                sc_q    <= '0;
                bc_q    <= '0;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end

          ST_DATA: begin
            if (sc_q == SC_LAST) begin
              sh_q <= {rxd_s_q, sh_q[DATA_WIDTH-1:1]};
              sc_q <= '0;
              bc_q <= bc_q + 1'b1;
              if (bc_q == BC_LAST) begin
                state_q <= ST_STOP;
              end
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end

          ST_STOP: begin
            if (sc_q == SC_LAST) begin
              if (!rxd_s_q) begin
                frame_err <= 1'b1;
              end else if (rx_fifo_full) begin
                overrun_err <= 1'b1;
              end else begin
                rx_data  <= sh_q;
                wr_en_rx <= 1'b1;
              end
              state_q <= ST_IDLE;
              sc_q    <= '0;
              busy    <= 1'b0;
            end else begin
              sc_q <= sc_q + 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core with BAUD_DIV=4 (64 clks per bit).
//   Frames are driven bit by bit on rxd; a monitor logs every write strobe and
//   error pulse, and each scenario compares the logged results against
//   hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int DW       = 8;
  localparam int BD       = 4;
  localparam int BIT_CLKS = 16 * BD;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd;
  logic          rx_fifo_full;
  logic [DW-1:0] rx_data;
  logic          wr_en_rx;
  logic          frame_err;
  logic          overrun_err;
  logic          busy;

  uart_rx_core #(
    .DATA_WIDTH(DW),
    .BAUD_DIV  (BD),
    .OVERSAMPLE(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .rx_fifo_full(rx_fifo_full),
    .rx_data     (rx_data),
    .wr_en_rx    (wr_en_rx),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Bookkeeping
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_n     = 0;
  int fe_n     = 0;
  int ov_n     = 0;
  int excl_bad = 0;
  int last_wr_cyc = 0;
  logic [DW-1:0] wr_log[$];

  always @(posedge clk) cyc++;

  // Output monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en_rx) begin
        wr_log.push_back(rx_data);
        wr_n++;
        last_wr_cyc = cyc;
      end
      if (frame_err)   fe_n++;
      if (overrun_err) ov_n++;
      if (int'(wr_en_rx) + int'(frame_err) + int'(overrun_err) > 1) excl_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pop_wr();
    if (wr_log.size() == 0) return 32'hDEAD_BEEF;
    return {24'h0, wr_log.pop_front()};
  endfunction

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_byte(input logic [DW-1:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, f0, o0, start_cyc, lat;
    logic saw_busy;

    reset        = 1'b1;
    rxd          = 1'b1;
    rx_fifo_full = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rx_data",     {24'h0, rx_data},     32'h0);
    check("rst_wr_en_rx",    {31'h0, wr_en_rx},    32'h0);
    check("rst_frame_err",   {31'h0, frame_err},   32'h0);
    check("rst_overrun_err", {31'h0, overrun_err}, 32'h0);
    check("rst_busy",        {31'h0, busy},        32'h0);
    reset = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 1: single good frame 0xA5, with latency window around mid stop bit.
    w0 = wr_n; f0 = fe_n; o0 = ov_n;
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    wait_idle("t1_busy_drop");
    lat = last_wr_cyc - start_cyc;
    check("t1_wr_count",  wr_n - w0, 1);
    check("t1_data",      pop_wr(), 32'hA5);
    check("t1_rx_data",   {24'h0, rx_data}, 32'hA5);
    check("t1_no_errors", (fe_n - f0) + (ov_n - o0), 0);
    check("t1_latency_ok", {31'h0, (lat >= 604 && lat <= 620)}, 32'h1);
    repeat (BIT_CLKS) @(negedge clk);

    // 2: back-to-back frames, no idle gap.
    w0 = wr_n; f0 = fe_n;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h55, 1'b1);
    wait_idle("t2_busy_drop");
    check("t2_wr_count", wr_n - w0, 3);
    check("t2_data0",    pop_wr(), 32'h00);
    check("t2_data1",    pop_wr(), 32'hFF);
    check("t2_data2",    pop_wr(), 32'h55);
    check("t2_no_ferr",  fe_n - f0, 0);
    repeat (BIT_CLKS) @(negedge clk);

    // 3: stop bit low -> framing error, then a good frame after idle high.
    w0 = wr_n; f0 = fe_n;
    send_byte(8'h3C, 1'b0);
    wait_idle("t3_busy_drop");
    check("t3_ferr_count", fe_n - f0, 1);
    check("t3_no_write",   wr_n - w0, 0);
    check("t3_rx_data_held", {24'h0, rx_data}, 32'h55);
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_byte(8'h81, 1'b1);
    wait_idle("t3b_busy_drop");
    check("t3b_wr_count", wr_n - w0, 1);
    check("t3b_data",     pop_wr(), 32'h81);
    check("t3b_ferr_unchanged", fe_n - f0, 1);
    repeat (BIT_CLKS) @(negedge clk);

    // 3c: stuck-low line (break) -> exactly one framing error, no restarts.
    w0 = wr_n; f0 = fe_n;
    rxd = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    check("t3c_ferr_once", fe_n - f0, 1);
    check("t3c_no_write",  wr_n - w0, 0);
    check("t3c_idle_low",  {31'h0, busy}, 32'h0);
    rxd = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 4: FIFO full -> overrun, data dropped, rx_data keeps 0x81.
    w0 = wr_n; o0 = ov_n;
    rx_fifo_full = 1'b1;
    send_byte(8'h7E, 1'b1);
    wait_idle("t4_busy_drop");
    rx_fifo_full = 1'b0;
    check("t4_ovr_count", ov_n - o0, 1);
    check("t4_no_write",  wr_n - w0, 0);
    check("t4_rx_data_held", {24'h0, rx_data}, 32'h81);
    repeat (BIT_CLKS) @(negedge clk);

    // 5: low glitch of 3 ticks (12 clks at BAUD_DIV=4) -> false start.
    w0 = wr_n; f0 = fe_n; o0 = ov_n;
    saw_busy = 1'b0;
    rxd = 1'b0;
    repeat (3 * BD) @(negedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      saw_busy |= busy;
      @(negedge clk);
    end
    check("t5_busy_seen", {31'h0, saw_busy}, 32'h1);
    wait_idle("t5_busy_drop");
    check("t5_no_pulses", (wr_n - w0) + (fe_n - f0) + (ov_n - o0), 0);
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 6: reset mid-DATA of 0xC3 (bits LSB first 1,1,0), then 0x42.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check("t6_busy_mid", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    check("t6_rst_busy",    {31'h0, busy}, 32'h0);
    check("t6_rst_rx_data", {24'h0, rx_data}, 32'h0);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    w0 = wr_n; f0 = fe_n; o0 = ov_n;
    send_byte(8'h42, 1'b1);
    wait_idle("t6_busy_drop");
    check("t6_wr_count",  wr_n - w0, 1);
    check("t6_data",      pop_wr(), 32'h42);
    check("t6_no_errors", (fe_n - f0) + (ov_n - o0), 0);
    check("log_drained",  wr_log.size(), 0);
    check("strobes_exclusive", excl_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
